// File: rtl/cache_pkg.sv
// cache_pkg: shared types and default sizing for the cache write/fill controller.
//   state_t          - controller state encoding (IDLE, EVICT, FILL, UPDATE)
//   DEF_LINE_WORDS   - default words per cache line
//   DEF_RAM_LATENCY  - default cycles from RAM read strobe to valid data
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVICT  = 2'd1,
        ST_FILL   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam int DEF_LINE_WORDS  = 4;
    localparam int DEF_RAM_LATENCY = 1;

endpackage

// File: rtl/component_register.sv
// component_register: load-enabled register, cleared by asynchronous reset.
//   clk  - clock
//   rst  - asynchronous active-high reset (q -> 0)
//   en   - load enable
//   d    - data in
//   q    - registered data out
module component_register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold value, load d when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/latency_counter.sv
// latency_counter: times the gap between a RAM read strobe and its data.
//   clk   - clock
//   rst   - asynchronous active-high reset
//   clear - synchronous abandon of any count in progress
//   start - pulse in the cycle the read strobe is issued
//   busy  - a read is in flight (start seen, done not yet given)
//   done  - one-cycle pulse RAM_LATENCY cycles after start
module latency_counter #(
    parameter int RAM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(RAM_LATENCY + 1);

    logic          busy_r;
    logic [CW-1:0] cnt_r;

    assign busy = busy_r;
    assign done = busy_r && (cnt_r == CW'(RAM_LATENCY));

    // Cycles elapsed since start; stops and drops busy once done fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
        end else if (clear) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
        end else if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= CW'(1);
        end else if (done) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
        end else if (busy_r) begin
            busy_r <= 1'b1;
            cnt_r  <= cnt_r + CW'(1);
        end else begin
            busy_r <= busy_r;
            cnt_r  <= cnt_r;
        end
    end

endmodule

// File: rtl/cache_write_ctrl.sv
// cache_write_ctrl: write/fill control for a direct-mapped cache.
// Hits complete in the request cycle; misses stall the CPU, optionally evict
// a dirty victim, refill the line word by word from fixed-latency RAM, write
// the tag and then complete the pending access.
//
// Build option: define CACHE_WRITE_BACK_EN for write-back (dirty bits,
// victim eviction). Left undefined the unit is write-through and `dirty`
// is ignored.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_valid/we/re/offset        - CPU request (write wins over read)
//   hit, dirty                    - tag-array lookup results in request cycle
//   req_ready, req_done           - idle/accepting, completion pulse
//   cache_we/word_sel/data_sel    - data-array write (data_sel 1 = RAM data)
//   ram_we/re/word_sel/victim_sel - main RAM access (victim_sel = eviction)
//   tag_we, tag_dirty, dirty_set  - tag-array update controls
module cache_write_ctrl
    import cache_pkg::*;
#(
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int RAM_LATENCY = DEF_RAM_LATENCY,
    parameter int OFFSET_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic                req_re,
    input  logic [OFFSET_W-1:0] req_offset,
    input  logic                hit,
    input  logic                dirty,
    output logic                req_ready,
    output logic                req_done,
    output logic                cache_we,
    output logic [OFFSET_W-1:0] cache_word_sel,
    output logic                cache_data_sel,
    output logic                ram_we,
    output logic                ram_re,
    output logic [OFFSET_W-1:0] ram_word_sel,
    output logic                ram_victim_sel,
    output logic                tag_we,
    output logic                tag_dirty,
    output logic                dirty_set
);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [OFFSET_W-1:0]   word_r;
    logic [OFFSET_W-1:0]   word_nxt_s;
    logic                  last_word_s;
    logic                  is_access_s;
    logic                  miss_s;
    logic                  pend_en_s;
    logic                  pend_we_s;
    logic [OFFSET_W-1:0]   pend_offset_s;
    logic                  lat_start_s;
    logic                  lat_clear_s;
    logic                  lat_busy_s;
    logic                  lat_done_s;

`ifndef CACHE_WRITE_BACK_EN
    // Write-through never looks at the victim's dirty bit.
    logic unused_dirty_s;
    assign unused_dirty_s = dirty;
`endif

    // A request with neither strobe set is serviced as a read hit.
    assign is_access_s = req_we || req_re;
    assign miss_s      = is_access_s && !hit;
    // With a single-word line the counter sits at 0 and every word is last.
    assign last_word_s = (word_r == OFFSET_W'(LINE_WORDS - 1));

    component_register #(.WIDTH(1)) u_pend_we (
        .clk (clk),
        .rst (rst),
        .en  (pend_en_s),
        .d   (req_we),
        .q   (pend_we_s)
    );

    component_register #(.WIDTH(OFFSET_W)) u_pend_offset (
        .clk (clk),
        .rst (rst),
        .en  (pend_en_s),
        .d   (req_offset),
        .q   (pend_offset_s)
    );

    latency_counter #(.RAM_LATENCY(RAM_LATENCY)) u_latency (
        .clk   (clk),
        .rst   (rst),
        .clear (lat_clear_s),
        .start (lat_start_s),
        .busy  (lat_busy_s),
        .done  (lat_done_s)
    );

    // State and word-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            word_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            word_r  <= word_nxt_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt_s    = state_r;
        word_nxt_s     = word_r;
        pend_en_s      = 1'b0;
        lat_start_s    = 1'b0;
        lat_clear_s    = 1'b0;
        req_ready      = 1'b0;
        req_done       = 1'b0;
        cache_we       = 1'b0;
        cache_word_sel = '0;
        cache_data_sel = 1'b0;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        ram_word_sel   = '0;
        ram_victim_sel = 1'b0;
        tag_we         = 1'b0;
        tag_dirty      = 1'b0;
        dirty_set      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && miss_s) begin
                    pend_en_s   = 1'b1;
                    word_nxt_s  = '0;
                    lat_clear_s = 1'b1;
`ifdef CACHE_WRITE_BACK_EN
                    if (dirty) begin
                        state_nxt_s = ST_EVICT;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
`else
                    state_nxt_s = ST_FILL;
`endif
                end else if (req_valid) begin
                    req_done = 1'b1;
                    if (req_we) begin
                        cache_we       = 1'b1;
                        cache_word_sel = req_offset;
`ifdef CACHE_WRITE_BACK_EN
                        dirty_set      = 1'b1;
                        tag_dirty      = 1'b1;
`else
                        ram_we         = 1'b1;
                        ram_word_sel   = req_offset;
`endif
                    end else begin
                        cache_we = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

`ifdef CACHE_WRITE_BACK_EN
            ST_EVICT: begin
                ram_we         = 1'b1;
                ram_word_sel   = word_r;
                ram_victim_sel = 1'b1;
                if (last_word_s) begin
                    word_nxt_s  = '0;
                    state_nxt_s = ST_FILL;
                end else begin
                    word_nxt_s = word_r + OFFSET_W'(1);
                end
            end
`endif

            ST_FILL: begin
                // Idle between a read strobe and its data while busy is up.
                if (!lat_busy_s) begin
                    ram_re       = 1'b1;
                    ram_word_sel = word_r;
                    lat_start_s  = 1'b1;
                end else if (lat_done_s) begin
                    cache_we       = 1'b1;
                    cache_word_sel = word_r;
                    cache_data_sel = 1'b1;
                    if (last_word_s) begin
                        word_nxt_s  = '0;
                        state_nxt_s = ST_UPDATE;
                    end else begin
                        word_nxt_s = word_r + OFFSET_W'(1);
                    end
                end else begin
                    ram_re = 1'b0;
                end
            end

            ST_UPDATE: begin
                tag_we      = 1'b1;
                req_done    = 1'b1;
                state_nxt_s = ST_IDLE;
`ifdef CACHE_WRITE_BACK_EN
                tag_dirty   = pend_we_s;
`endif
                if (pend_we_s) begin
                    cache_we       = 1'b1;
                    cache_word_sel = pend_offset_s;
`ifndef CACHE_WRITE_BACK_EN
                    ram_we         = 1'b1;
                    ram_word_sel   = pend_offset_s;
`endif
                end else begin
                    cache_we = 1'b0;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule
